// File: rtl/fifo_depth_level_if.sv
// fifo_depth_level_if: ENQ/DEQ/CLR handshake bundle for fifo_depth_level.
//   master: producer/consumer side, drives D_IN, ENQ, DEQ, CLR.
//   slave : FIFO side, drives D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY.
interface fifo_depth_level_if #(
    parameter int width    = 1,
    parameter int cntwidth = 3
);
    logic [width-1:0]    D_IN;
    logic                ENQ;
    logic                DEQ;
    logic                CLR;
    logic [width-1:0]    D_OUT;
    logic                FULL_N;
    logic                EMPTY_N;
    logic [cntwidth-1:0] COUNT;
    logic                ALMOST_FULL;
    logic                ALMOST_EMPTY;

    modport master (
        output D_IN, ENQ, DEQ, CLR,
        input  D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY
    );

    modport slave (
        input  D_IN, ENQ, DEQ, CLR,
        output D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY
    );
endinterface

// File: rtl/fifo_depth_level.sv
// fifo_depth_level: parametrised-depth FIFO with occupancy count and almost-full/almost-empty flags.
//   CLK   : clock, all state updates on the rising edge.
//   RST_N : asynchronous active-low reset.
//   f     : slave side of fifo_depth_level_if (D_IN/ENQ/DEQ/CLR in; D_OUT, FULL_N, EMPTY_N,
//           COUNT, ALMOST_FULL, ALMOST_EMPTY out). All flags are registered.
module fifo_depth_level #(
    parameter int width        = 1,
    parameter int depth        = 4,
    parameter int cntwidth     = 3,
    parameter int afull_level  = 3,
    parameter int aempty_level = 1,
    parameter bit guarded      = 1'b1
) (
    input logic CLK,
    input logic RST_N,
    fifo_depth_level_if.slave f
);
    localparam int pw = $clog2(depth);

`ifndef SYNTHESIS
    if (depth < 2 || (2 ** cntwidth) <= depth || afull_level < 1 || afull_level > depth ||
        aempty_level < 0 || aempty_level >= depth) begin : g_bad_params
        $fatal(1, "fifo_depth_level: illegal parameter combination");
    end
`endif

    logic [width-1:0]    mem [depth];
    logic [pw-1:0]       head_q, head_d, tail_q, tail_d;
    logic [cntwidth-1:0] count_q, count_d;
    logic                full_n_q, full_n_d, empty_n_q, empty_n_d;
    logic                afull_q, afull_d, aempty_q, aempty_d;
    logic                enq_acc, deq_acc, wr_en;

    // Pointers wrap explicitly at depth-1 so non-power-of-two depths never alias.
    function automatic logic [pw-1:0] inc(input logic [pw-1:0] p);
        return (p == pw'(depth - 1)) ? '0 : p + pw'(1);
    endfunction

    always_comb begin
        deq_acc   = f.DEQ && empty_n_q;
        // Unguarded: a simultaneous dequeue frees the slot the enqueue takes while full.
        enq_acc   = f.ENQ && (full_n_q || (!guarded && f.DEQ && empty_n_q));
        wr_en     = enq_acc && !f.CLR;
        head_d    = f.CLR ? '0 : deq_acc ? inc(head_q) : head_q;
        tail_d    = f.CLR ? '0 : enq_acc ? inc(tail_q) : tail_q;
        count_d   = f.CLR ? '0 : count_q + cntwidth'(enq_acc) - cntwidth'(deq_acc);
        full_n_d  = count_d != cntwidth'(depth);
        empty_n_d = count_d != '0;
        afull_d   = count_d >= cntwidth'(afull_level);
        aempty_d  = count_d <= cntwidth'(aempty_level);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[tail_q] <= f.D_IN;
    end

    assign f.D_OUT        = mem[head_q];
    assign f.FULL_N       = full_n_q;
    assign f.EMPTY_N      = empty_n_q;
    assign f.COUNT        = count_q;
    assign f.ALMOST_FULL  = afull_q;
    assign f.ALMOST_EMPTY = aempty_q;

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (RST_N && f.DEQ && !empty_n_q) $warning("Dequeuing from empty fifo");
        if (RST_N && f.ENQ && !full_n_q && (!f.DEQ || guarded)) $warning("Enqueuing to a full fifo");
    end
`endif
endmodule

// File: tb/tb_fifo_depth_level.sv
// tb_fifo_depth_level: directed bench for fifo_depth_level, guarded and unguarded copies side by side.
module tb_fifo_depth_level;
    typedef logic [7:0] q_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       arm = 1'b0;
    logic       enq = 1'b0, deq = 1'b0, clr = 1'b0;
    logic [7:0] din = 8'h00;
    q_t         q0, q1;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    fifo_depth_level_if #(.width(8), .cntwidth(3)) i0 ();
    fifo_depth_level_if #(.width(8), .cntwidth(3)) i1 ();

    assign i0.D_IN = din;
    assign i0.ENQ  = enq;
    assign i0.DEQ  = deq;
    assign i0.CLR  = clr;
    assign i1.D_IN = din;
    assign i1.ENQ  = enq;
    assign i1.DEQ  = deq;
    assign i1.CLR  = clr;

    fifo_depth_level #(.width(8), .depth(5), .cntwidth(3), .afull_level(3), .aempty_level(1), .guarded(1'b0))
        u0 (.CLK(clk), .RST_N(rst_n), .f(i0));
    fifo_depth_level #(.width(8), .depth(5), .cntwidth(3), .afull_level(3), .aempty_level(1), .guarded(1'b1))
        u1 (.CLK(clk), .RST_N(rst_n), .f(i1));

    // Queue model: a FIFO of at most 5 bytes; flags derived from its size.
    task automatic step(input bit g, input q_t qi, output q_t qo);
        int  n;
        bit  de, en;
        qo = qi;
        n  = qi.size();
        if (clr) begin
            qo.delete();
        end else begin
            de = deq && n > 0;
            en = enq && (n < 5 || (!g && deq && n > 0));
            if (de) void'(qo.pop_front());
            if (en) qo.push_back(din);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            step(1'b0, q0, q0);
            step(1'b1, q1, q1);
        end
    end

    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, want, want, $time);
        end
    endtask

    task automatic cmp(input string tag, input logic [2:0] cnt, input logic fn, input logic en,
                       input logic af, input logic ae, input logic [7:0] dout, input q_t q);
        chk({tag, ".COUNT"}, int'(cnt), q.size());
        chk({tag, ".FULL_N"}, int'(fn), int'(q.size() < 5));
        chk({tag, ".EMPTY_N"}, int'(en), int'(q.size() > 0));
        chk({tag, ".ALMOST_FULL"}, int'(af), int'(q.size() >= 3));
        chk({tag, ".ALMOST_EMPTY"}, int'(ae), int'(q.size() <= 1));
        if (q.size() > 0) chk({tag, ".D_OUT"}, int'(dout), int'(q[0]));
    endtask

    always @(negedge clk) begin
        if (arm) begin
            cmp("unguarded", i0.COUNT, i0.FULL_N, i0.EMPTY_N, i0.ALMOST_FULL, i0.ALMOST_EMPTY, i0.D_OUT, q0);
            cmp("guarded", i1.COUNT, i1.FULL_N, i1.EMPTY_N, i1.ALMOST_FULL, i1.ALMOST_EMPTY, i1.D_OUT, q1);
        end
    end

    // Inputs change on the falling edge and are consumed by the next rising edge.
    task automatic op(input logic e, input logic d, input logic c, input logic [7:0] v);
        @(negedge clk);
        enq = e;
        deq = d;
        clr = c;
        din = v;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        arm = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset COUNT", int'(i0.COUNT), 0);
        chk("reset FULL_N", int'(i0.FULL_N), 1);
        chk("reset EMPTY_N", int'(i0.EMPTY_N), 0);
        chk("reset ALMOST_EMPTY", int'(i0.ALMOST_EMPTY), 1);
        chk("reset ALMOST_FULL", int'(i0.ALMOST_FULL), 0);
        rst_n = 1'b1;

        // Fill and drain.
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        idle();
        chk("fill COUNT", int'(i0.COUNT), 5);
        chk("fill FULL_N", int'(i0.FULL_N), 0);
        chk("fill ALMOST_FULL", int'(i0.ALMOST_FULL), 1);
        for (int i = 0; i < 5; i++) begin
            op(1'b0, 1'b1, 1'b0, 8'h00);
            chk("drain D_OUT", int'(i0.D_OUT), 8'h10 + i);
        end
        idle();
        chk("drain EMPTY_N", int'(i0.EMPTY_N), 0);
        chk("drain ALMOST_EMPTY", int'(i0.ALMOST_EMPTY), 1);

        // Wrap-around.
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 1'b0, 8'(8'hF0 + i));
        for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) op(1'b1, 1'b1, 1'b0, 8'(i));
        idle();
        chk("wrap COUNT", int'(i0.COUNT), 1);
        chk("wrap last D_OUT", int'(i0.D_OUT), 11);
        op(1'b0, 1'b1, 1'b0, 8'h00);

        // Simultaneous ENQ+DEQ while full.
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b0, 8'(8'h01 + i));
        op(1'b1, 1'b1, 1'b0, 8'hAA);
        idle();
        chk("full-sim unguarded COUNT", int'(i0.COUNT), 5);
        chk("full-sim guarded COUNT", int'(i1.COUNT), 4);
        chk("full-sim unguarded FULL_N", int'(i0.FULL_N), 0);
        for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 1'b0, 8'h00);
        idle();
        chk("full-sim unguarded tail D_OUT", int'(i0.D_OUT), 8'hAA);
        chk("full-sim guarded EMPTY_N", int'(i1.EMPTY_N), 0);
        op(1'b0, 1'b1, 1'b0, 8'h00);

        // ENQ+DEQ on empty.
        op(1'b1, 1'b1, 1'b0, 8'h3C);
        idle();
        chk("empty-sim COUNT", int'(i0.COUNT), 1);
        chk("empty-sim EMPTY_N", int'(i1.EMPTY_N), 1);
        chk("empty-sim D_OUT", int'(i1.D_OUT), 8'h3C);
        op(1'b0, 1'b1, 1'b0, 8'h00);

        // CLR beats ENQ/DEQ.
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        op(1'b1, 1'b1, 1'b1, 8'h77);
        idle();
        chk("clr COUNT", int'(i0.COUNT), 0);
        chk("clr EMPTY_N", int'(i0.EMPTY_N), 0);
        chk("clr FULL_N", int'(i0.FULL_N), 1);
        chk("clr ALMOST_EMPTY", int'(i0.ALMOST_EMPTY), 1);
        op(1'b1, 1'b0, 1'b0, 8'h55);
        idle();
        chk("post-clr D_OUT", int'(i0.D_OUT), 8'h55);
        op(1'b0, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset between edges at count 4.
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        idle();
        chk("pre-reset COUNT", int'(i0.COUNT), 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async COUNT", int'(i0.COUNT), 0);
        chk("async EMPTY_N", int'(i0.EMPTY_N), 0);
        chk("async FULL_N", int'(i0.FULL_N), 1);
        chk("async ALMOST_FULL", int'(i0.ALMOST_FULL), 0);
        chk("async ALMOST_EMPTY", int'(i1.ALMOST_EMPTY), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(1'b1, 1'b0, 1'b0, 8'h66);
        idle();
        chk("resume COUNT", int'(i0.COUNT), 1);
        chk("resume D_OUT", int'(i0.D_OUT), 8'h66);
        op(1'b0, 1'b1, 1'b0, 8'h00);
        idle();
        idle();

        arm = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
